alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default `WORD, operand and result width in bits (>= 4).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, width of the multiply step counter.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  in  1  operands and opcode present.
REQ-006 SHALL have port in_ready  out  1  block accepts an operation this cycle.
REQ-007 SHALL have port a_in  in  WIDTH  operand A.
REQ-008 SHALL have port b_in  in  WIDTH  operand B.
REQ-009 SHALL have port alu_control  in  4  opcode: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASS, ALU_MUL.
REQ-010 SHALL have port out_valid  out  1  result and flags valid.
REQ-011 SHALL have port out_ready  in  1  consumer takes the result this cycle.
REQ-012 SHALL have port alu_result  out  WIDTH  registered result.
REQ-013 SHALL have ports zero_flag, neg_flag, carry_flag, ovf_flag  out  1 each  registered Z, N, C, V.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DONE.
REQ-015 SHALL drive in_ready = (state==IDLE) or (state==DONE and out_ready).
REQ-016 Transfer SHALL occur when in_valid and in_ready are both high; operands and opcode are latched then.
REQ-017 AND, OR, ADD, SUB, PASS SHALL have latency 1: accepted at edge N, out_valid high after edge N+1, state DONE.
REQ-018 PASS SHALL output b_in; AND/OR bitwise; ADD a+b mod 2^WIDTH; SUB a-b mod 2^WIDTH.
REQ-019 ALU_MUL SHALL enter MUL and perform unsigned shift-add, one multiplier bit per cycle, exactly WIDTH cycles, then DONE; alu_result = low WIDTH bits of a*b; out_valid high WIDTH+1 cycles after acceptance.
REQ-020 Flags: Z = (result==0); N = result[WIDTH-1]; all ops.
REQ-021 ADD: C = carry out of bit WIDTH-1; V = signed overflow (operands same sign, result sign differs).
REQ-022 SUB: C = NOT borrow (1 when a >= b unsigned); V = operands differ in sign and result sign differs from a.
REQ-023 AND, OR, PASS, MUL: C = 0, V = 0.
REQ-024 Undefined opcode SHALL complete with latency 1, result 0, Z=1, N=C=V=0.
REQ-025 In DONE with out_ready low, result and flags SHALL hold stable and out_valid stay high.
REQ-026 In DONE with out_ready high and no new transfer: next state IDLE, out_valid low.
REQ-027 In DONE with out_ready high and a simultaneous transfer: result consumed and new op accepted same cycle, no bubble.
REQ-028 During MUL, in_valid SHALL be ignored (in_ready low); operands latched at acceptance are unaffected by input changes.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, out_valid 0, alu_result 0, all flags 0, step counter 0, regardless of operation in progress.
REQ-030 After rst_n deasserts, in_ready SHALL be 1 on the first cycle; an aborted MUL produces no result.

Structure
REQ-031 `WORD and all ALU_* opcodes SHALL live in definitions.vh; ALU_MUL takes an unused 4-bit encoding; existing encodings unchanged.
REQ-032 Iterative multiplier datapath (accumulator, shifted multiplicand, counter) SHALL be a sub-module alu_mul_iter with start/done pins.

Verification
REQ-033 WIDTH=32, a=5, b=15: AND->5, OR->15, ADD->20, PASS->15, each out_valid one cycle after acceptance; SUB->0xFFFFFFF6, N=1, C=0.
REQ-034 a=b=23: SUB->0, Z=1, C=1, V=0; ADD 0x7FFFFFFF+1 ->0x80000000, N=1, V=1, C=0; ADD 0xFFFFFFFF+1 ->0, Z=1, C=1.
REQ-035 MUL 7*6 ->42, in_ready low for 32 cycles, out_valid 33 cycles after acceptance; MUL 0x10000*0x10000 ->0, Z=1.
REQ-036 out_ready held low 5 cycles in DONE -> result/flags stable, in_ready low; then out_ready high with in_valid high -> back-to-back accept.
REQ-037 rst_n pulsed low mid-MUL (cycle 10) -> outputs 0 immediately, in_ready 1 after release, no stale out_valid.
REQ-038 Undefined opcode -> result 0, Z=1, latency 1.

Source files
------------

// File: rtl/alu_multicycle_pkg.sv
// Shared definitions for the multicycle ALU: word size, opcode encodings, flag bundle.
package alu_multicycle_pkg;

    localparam int WORD = 32;

    // ALU_MUL takes a previously unused slot; the older encodings keep their values.
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_PASS = 4'b1000;
    localparam logic [3:0] ALU_MUL  = 4'b1001;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle of the multicycle ALU, with producer (master) and ALU (slave) views.
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    // A beat moves when valid and ready are high together at a rising edge; a raised
    // valid and its payload stay put until that happens, and ready never waits on valid.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [3:0]       alu_control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_result;
    logic             zero_flag;
    logic             neg_flag;
    logic             carry_flag;
    logic             ovf_flag;

    modport master (
        output in_valid, a_in, b_in, alu_control, out_ready,
        input  in_ready, out_valid, alu_result, zero_flag, neg_flag, carry_flag, ovf_flag
    );

    modport slave (
        input  in_valid, a_in, b_in, alu_control, out_ready,
        output in_ready, out_valid, alu_result, zero_flag, neg_flag, carry_flag, ovf_flag
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module alu_mul_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] step_acc;

    // done is raised during the final step, so product already includes the last partial sum.
    assign step_acc = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign done     = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign product  = step_acc;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = step_acc;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (done) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle logic/arithmetic ops plus an iterative multiply, valid/ready on both sides.
module alu_multicycle
    import alu_multicycle_pkg::*;
#(
    parameter int WIDTH = WORD,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero_flag,
    output logic             neg_flag,
    output logic             carry_flag,
    output logic             ovf_flag,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    alu_flags_t       flags_q, flags_d;

    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] quick_res;
    logic             quick_c;
    logic             quick_v;

    // DONE with out_ready high can take a new op in the same cycle the result leaves.
    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (alu_control == ALU_MUL);

    alu_mul_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a_in),
        .b       (b_in),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle ops; unknown opcodes fall through to zero with C=V=0.
    always_comb begin
        sum_ext   = {1'b0, a_in} + {1'b0, b_in};
        diff_ext  = {1'b0, a_in} - {1'b0, b_in};
        quick_res = '0;
        quick_c   = 1'b0;
        quick_v   = 1'b0;
        case (alu_control)
            ALU_AND:  quick_res = a_in & b_in;
            ALU_OR:   quick_res = a_in | b_in;
            ALU_PASS: quick_res = b_in;
            ALU_ADD: begin
                quick_res = sum_ext[WIDTH-1:0];
                quick_c   = sum_ext[WIDTH];
                quick_v   = (a_in[WIDTH-1] == b_in[WIDTH-1]) &&
                            (sum_ext[WIDTH-1] != a_in[WIDTH-1]);
            end
            ALU_SUB: begin
                quick_res = diff_ext[WIDTH-1:0];
                quick_c   = ~diff_ext[WIDTH];
                quick_v   = (a_in[WIDTH-1] != b_in[WIDTH-1]) &&
                            (diff_ext[WIDTH-1] != a_in[WIDTH-1]);
            end
            default: quick_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            S_MUL: begin
                if (mul_done) begin
                    state_d   = S_DONE;
                    result_d  = mul_product;
                    flags_d.z = (mul_product == '0);
                    flags_d.n = mul_product[WIDTH-1];
                    flags_d.c = 1'b0;
                    flags_d.v = 1'b0;
                end
            end
            default: begin
                if (accept) begin
                    if (alu_control == ALU_MUL) begin
                        state_d = S_MUL;
                    end else begin
                        state_d   = S_DONE;
                        result_d  = quick_res;
                        flags_d.z = (quick_res == '0);
                        flags_d.n = quick_res[WIDTH-1];
                        flags_d.c = quick_c;
                        flags_d.v = quick_v;
                    end
                end else if ((state_q == S_DONE) && out_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign out_valid  = (state_q == S_DONE);
    assign alu_result = result_q;
    assign zero_flag  = flags_q.z;
    assign neg_flag   = flags_q.n;
    assign carry_flag = flags_q.c;
    assign ovf_flag   = flags_q.v;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: single-cycle ops, flags, multiply timing, backpressure, reset abort.
module tb_alu_multicycle;
    import alu_multicycle_pkg::*;

    localparam int W = 32;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [W-1:0] exp_q[$];

    alu_multicycle_if #(.WIDTH(W)) bus ();

    alu_multicycle #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (bus.in_valid),
        .in_ready    (bus.in_ready),
        .a_in        (bus.a_in),
        .b_in        (bus.b_in),
        .alu_control (bus.alu_control),
        .out_valid   (bus.out_valid),
        .out_ready   (bus.out_ready),
        .alu_result  (bus.alu_result),
        .zero_flag   (bus.zero_flag),
        .neg_flag    (bus.neg_flag),
        .carry_flag  (bus.carry_flag),
        .ovf_flag    (bus.ovf_flag),
        .dbg_state   (dbg_state)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {bus.zero_flag, bus.neg_flag, bus.carry_flag, bus.ovf_flag};
    endfunction

    // One full transaction from IDLE; flags are packed {Z,N,C,V}.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] op, input logic [W-1:0] exp_res,
                          input logic [3:0] exp_flags, input int exp_lat, input bit noise);
        int lat;
        int low;
        exp_q.push_back(exp_res);
        @(negedge clk);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        bus.in_valid    = 1'b1;
        bus.a_in        = a;
        bus.b_in        = b;
        bus.alu_control = op;
        @(posedge clk);
        #1;
        if (noise) begin
            bus.a_in        = $urandom;
            bus.b_in        = $urandom;
            bus.alu_control = ALU_ADD;
        end else begin
            bus.in_valid = 1'b0;
        end
        lat = 0;
        low = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
            if (!bus.in_ready) low++;
            if (noise) begin
                bus.a_in = $urandom;
                bus.b_in = $urandom;
            end
        end
        bus.in_valid = 1'b0;
        check({tag, "_latency"}, lat, exp_lat);
        if (op == ALU_MUL) check({tag, "_busy_cycles"}, low, W);
        check({tag, "_result"}, bus.alu_result, exp_q.pop_front());
        check({tag, "_flags"}, flags_now(), exp_flags);
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.a_in        = '0;
        bus.b_in        = '0;
        bus.alu_control = ALU_AND;
        bus.out_ready   = 1'b1;
        rst_n           = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_result", bus.alu_result, 0);
        check("reset_flags", flags_now(), 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", bus.in_ready, 1);

        run_op("and",  32'd5, 32'd15, ALU_AND,  32'd5,  4'b0000, 1, 1'b0);
        run_op("or",   32'd5, 32'd15, ALU_OR,   32'd15, 4'b0000, 1, 1'b0);
        run_op("add",  32'd5, 32'd15, ALU_ADD,  32'd20, 4'b0000, 1, 1'b0);
        run_op("pass", 32'd5, 32'd15, ALU_PASS, 32'd15, 4'b0000, 1, 1'b0);
        run_op("sub_neg", 32'd5, 32'd15, ALU_SUB, 32'hFFFF_FFF6, 4'b0100, 1, 1'b0);
        run_op("sub_eq", 32'd23, 32'd23, ALU_SUB, 32'd0, 4'b1010, 1, 1'b0);
        run_op("add_ovf", 32'h7FFF_FFFF, 32'd1, ALU_ADD, 32'h8000_0000, 4'b0101, 1, 1'b0);
        run_op("undef", 32'd5, 32'd15, 4'b1110, 32'd0, 4'b1000, 1, 1'b0);
        run_op("add_wrap", 32'hFFFF_FFFF, 32'd1, ALU_ADD, 32'd0, 4'b1010, 1, 1'b0);
        run_op("mul_7x6", 32'd7, 32'd6, ALU_MUL, 32'd42, 4'b0000, 33, 1'b1);
        run_op("mul_hi", 32'h0001_0000, 32'h0001_0000, ALU_MUL, 32'd0, 4'b1000, 33, 1'b0);
        run_op("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, ALU_MUL, 32'd1, 4'b0000, 33, 1'b0);
        run_op("mul_mid", 32'd123, 32'd456, ALU_MUL, 32'd56088, 4'b0000, 33, 1'b0);

        // backpressure: hold in DONE, then consume and accept in the same edge
        @(negedge clk);
        bus.out_ready   = 1'b0;
        bus.in_valid    = 1'b1;
        bus.a_in        = 32'd3;
        bus.b_in        = 32'd4;
        bus.alu_control = ALU_ADD;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("hold_first_valid", bus.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", bus.out_valid, 1);
            check("hold_result", bus.alu_result, 32'd7);
            check("hold_flags", flags_now(), 4'b0000);
            check("hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready   = 1'b1;
        bus.in_valid    = 1'b1;
        bus.a_in        = 32'h0000_00F0;
        bus.b_in        = 32'h0000_000F;
        bus.alu_control = ALU_OR;
        #1 check("b2b_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid", bus.out_valid, 1);
        check("b2b_result", bus.alu_result, 32'h0000_00FF);

        // reset in the middle of a multiply
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.a_in        = 32'd7;
        bus.b_in        = 32'd6;
        bus.alu_control = ALU_MUL;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_mul_state", dbg_state, 2'd1);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.alu_result, 0);
        check("rst_flags", flags_now(), 4'b0000);
        check("rst_state", dbg_state, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_out_valid", bus.out_valid, 0);
        begin
            int stale;
            stale = 0;
            repeat (40) begin
                @(negedge clk);
                if (bus.out_valid) stale++;
            end
            check("post_rst_no_stale", stale, 0);
        end
        run_op("recover", 32'd1, 32'd1, ALU_ADD, 32'd2, 4'b0000, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
